// File: rtl/flag_input_capture_if.sv
// rtl/flag_input_capture_if.sv - event inputs and flag set-pulse outputs of flag_input_capture
interface flag_input_capture_if #(
  parameter int N_INPUTS = 7
);
  logic [N_INPUTS-1:0] raw_in;
  logic [N_INPUTS-1:0] edge_sel;
  logic                capture_en;
  logic [7:0]          flag_inputs;
  logic [N_INPUTS-1:0] stable_out;

  modport master (
    output raw_in,
    output edge_sel,
    output capture_en,
    input  flag_inputs,
    input  stable_out
  );

  modport slave (
    input  raw_in,
    input  edge_sel,
    input  capture_en,
    output flag_inputs,
    output stable_out
  );
endinterface

// File: rtl/flag_input_capture.sv
// rtl/flag_input_capture.sv - sync, debounce and edge-detect raw events into FLAG set pulses
module flag_input_capture #(
  parameter  int N_INPUTS        = 7,
  parameter  int DEBOUNCE_CYCLES = 500000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  flag_input_capture_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_INPUTS-1:0] s1;
  logic [N_INPUTS-1:0] s2;
  logic [N_INPUTS-1:0] stable;
  logic [N_INPUTS-1:0] pulse;
  logic [CNT_W-1:0]    cnt [N_INPUTS];

  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      pulse  <= '0;
      for (int i = 0; i < N_INPUTS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= bus.raw_in;
      s2 <= s1;
      for (int i = 0; i < N_INPUTS; i++) begin
        pulse[i] <= 1'b0;
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          // Accepted transition: the new level itself is the edge direction.
          stable[i] <= s2[i];
          cnt[i]    <= '0;
          pulse[i]  <= bus.capture_en && (s2[i] == bus.edge_sel[i]);
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign bus.flag_inputs = {{(8 - N_INPUTS){1'b0}}, pulse};
  assign bus.stable_out  = stable;

endmodule

// File: tb/tb_flag_input_capture.sv
// tb/tb_flag_input_capture.sv - directed plus randomized bench against a sliding-window reference model
module tb_flag_input_capture;

  localparam int N = 7;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  flag_input_capture_if #(.N_INPUTS(N)) bus ();

  flag_input_capture #(
    .N_INPUTS        (N),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference: a channel accepts a new level once the last D synchronised
  // samples (each being raw_in from two edges earlier) all disagree with it.
  logic [N-1:0] raw_q [$];
  bit           rst_q [$];
  logic [N-1:0] m_stable = '0;
  logic [7:0]   m_flag   = '0;

  function automatic bit seen(int k, int i);
    if (k < 2) return 1'b0;
    if (rst_q[k-1] || rst_q[k-2]) return 1'b0;
    return raw_q[k-2][i];
  endfunction

  always @(posedge clk) begin
    int k;
    bit ok;
    raw_q.push_back(bus.raw_in);
    rst_q.push_back(reset);
    k = raw_q.size() - 1;
    m_flag = 8'h00;
    if (reset) begin
      m_stable = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        ok = 1'b1;
        for (int j = 0; j < D; j++) begin
          if (k - j < 0) ok = 1'b0;
          else if (rst_q[k-j]) ok = 1'b0;
          else if (seen(k - j, i) == m_stable[i]) ok = 1'b0;
        end
        if (ok) begin
          m_stable[i] = ~m_stable[i];
          m_flag[i]   = bus.capture_en && (m_stable[i] == bus.edge_sel[i]);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    check("model_flag", bus.flag_inputs, m_flag);
    check("model_stable", 32'(bus.stable_out), 32'(m_stable));
  endtask

  task automatic run_expect(input string tag, input int n, input int at, input logic [7:0] p);
    for (int k = 1; k <= n; k++) begin
      step();
      check(tag, bus.flag_inputs, (k == at) ? p : 8'h00);
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.raw_in   = '0;
    step();
    check("reset_flag", bus.flag_inputs, 8'h00);
    check("reset_stable", 32'(bus.stable_out), 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    bus.raw_in     = '0;
    bus.edge_sel   = 7'h7F;
    bus.capture_en = 1'b1;
    step();
    do_reset();

    // single rising event
    bus.raw_in[0] = 1'b1;
    run_expect("rise_ch0", 10, 6, 8'h01);
    check("rise_ch0_stable", 32'(bus.stable_out[0]), 32'h1);

    // bounce shorter than threshold, then a real rise
    do_reset();
    bus.raw_in[2] = 1'b1;
    run_expect("bounce_hi", 3, 0, 8'h00);
    bus.raw_in[2] = 1'b0;
    run_expect("bounce_lo", 6, 0, 8'h00);
    check("bounce_stable", 32'(bus.stable_out[2]), 32'h0);
    bus.raw_in[2] = 1'b1;
    run_expect("rise_ch2", 10, 6, 8'h04);

    // falling-edge selection
    do_reset();
    bus.edge_sel[1] = 1'b0;
    bus.raw_in[1]   = 1'b1;
    run_expect("fall_sel_rise", 8, 0, 8'h00);
    bus.raw_in[1]   = 1'b0;
    run_expect("fall_sel_fall", 8, 6, 8'h02);
    bus.edge_sel    = 7'h7F;

    // simultaneous channels
    do_reset();
    bus.raw_in[3] = 1'b1;
    bus.raw_in[6] = 1'b1;
    run_expect("multi", 8, 6, 8'h48);

    // capture disabled: level tracked, no pulse, no late pulse
    do_reset();
    bus.capture_en = 1'b0;
    bus.raw_in[5]  = 1'b1;
    run_expect("cap_off", 8, 0, 8'h00);
    check("cap_off_stable", 32'(bus.stable_out[5]), 32'h1);
    bus.capture_en = 1'b1;
    run_expect("cap_reen", 4, 0, 8'h00);

    // reset mid-debounce with input held high
    do_reset();
    bus.raw_in[0] = 1'b1;
    run_expect("pre_rst", 4, 0, 8'h00);
    reset = 1'b1;
    step();
    check("mid_rst_flag", bus.flag_inputs, 8'h00);
    reset = 1'b0;
    run_expect("post_rst", 8, 6, 8'h01);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) bus.raw_in[i] = ~bus.raw_in[i];
      end
      if ($urandom_range(0, 49) == 0) bus.edge_sel = 7'($urandom);
      bus.capture_en = ($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 299) == 0);
      step();
      check("bit7", 32'(bus.flag_inputs[7]), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/flag_input_capture.md
Name: flag_input_capture

Overview:
- Upstream feeder of the register file FLAG set-bit inputs.
- Synchronises up to 7 raw asynchronous event sources (push-buttons, external strobes), debounces each, detects the selected edge, and emits single-cycle set pulses on flag_inputs.
- The register file ORs those pulses into FLAG bits 0..6 every cycle.
- Sole producer of flag_inputs; bit 7 is never driven high.

Parameters:
- N_INPUTS, 7, number of event channels; legal 1..7; channel i drives flag_inputs[i].
- DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronised level must differ from the stable level before acceptance; legal >= 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), per-channel counter width (derived, not overridden).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- raw_in  input  N_INPUTS  asynchronous raw event levels, active-high.
- edge_sel  input  N_INPUTS  per channel: 1 = pulse on accepted rising transition, 0 = pulse on accepted falling transition.
- capture_en  input  1  global pulse enable; when 0, debouncing continues but no pulses are emitted.
- flag_inputs  output  8  registered one-cycle set pulses to the register file; bits N_INPUTS..7 tied 0.
- stable_out  output  N_INPUTS  registered debounced level per channel (for GPIO/debug readback).

Behaviour:
- Reset (reset=1 at a clk edge): sync stage 1 and 2 = 0, stable = 0, counters = 0, flag_inputs = 8'h00, stable_out = 0. Reset dominates all other inputs in that cycle. Reset mid-debounce discards the partial count; no pulse is emitted on the reset cycle or the cycle after.
- Sync: raw_in -> s1 -> s2 (two flops per channel, no logic between).
- Debounce, per channel each cycle:
  - If s2 == stable: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= s2; counter <= 0; candidate edge = rising if s2 == 1, else falling.
  - Else: counter <= counter + 1.
- Any glitch back to the stable level before the threshold clears the counter. Counter never exceeds DEBOUNCE_CYCLES-1, so it never wraps.
- Pulse: flag_inputs[i] is registered 1 in the same edge that stable[i] updates, iff capture_en==1 at that edge and the edge direction matches edge_sel[i]. Otherwise it is 0.
  - Pulse width is exactly one cycle; it never stays high two consecutive cycles.
  - A channel pulses at most once per accepted transition.
- Latency: raw change first sampled at edge E1 -> stable/pulse updated at edge E(DEBOUNCE_CYCLES+2); i.e. DEBOUNCE_CYCLES+2 cycles.
- Channel independence: simultaneous acceptances on several channels produce simultaneous pulses in the same cycle (multi-bit flag_inputs is legal).
- edge_sel and capture_en are sampled at the acceptance edge only. Changing them mid-debounce does not restart the count.
- Input held high through reset: after release it is accepted as a rising transition DEBOUNCE_CYCLES+2 cycles later, and pulses if edge_sel=1 and capture_en=1.
- stable_out = stable (registered, no added delay).

Test Plan (DEBOUNCE_CYCLES=4, N_INPUTS=7):
1. Reset, then raw_in[0] 0->1 sampled at edge 1, held; edge_sel=7'h7F, capture_en=1 -> flag_inputs=8'h01 for exactly one cycle after edge 6, stable_out[0]=1 from edge 6, flag_inputs=0 thereafter.
2. raw_in[2] pulses high for 3 cycles then low (bounce) -> no pulse, stable_out[2] stays 0; then held high 10 cycles -> single 8'h04 pulse 6 cycles after the final rise is sampled.
3. edge_sel[1]=0, raw_in[1] rises and later falls, each held 8 cycles -> no pulse on the rise; one 8'h02 pulse 6 cycles after the fall is sampled.
4. raw_in[3] and raw_in[6] rise on the same cycle -> flag_inputs=8'h48 in one cycle, bit 7 always 0.
5. capture_en=0 while raw_in[5] rises and is accepted -> stable_out[5]=1, flag_inputs stays 8'h00; re-enabling afterwards produces no late pulse.
6. reset asserted when the channel 0 counter is at 2 -> flag_inputs=0 and counter cleared; raw_in[0] still high -> pulse 8'h01 exactly 6 cycles after reset deasserts.
